// File: rtl/jt900h_blkxfer_if.sv
// Memory-side handshake bus of the TLCS-900H block-transfer sequencer.
// The master issues rd/wr requests that are held until mem_ack.
interface jt900h_blkxfer_if #(
    parameter int AW = 24
);
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic          mem_wr;
    logic [15:0]   mem_dout;
    logic [15:0]   mem_din;
    logic          mem_ack;

    modport master (
        output mem_addr, mem_rd, mem_wr, mem_dout,
        input  mem_din, mem_ack
    );

    modport slave (
        input  mem_addr, mem_rd, mem_wr, mem_dout,
        output mem_din, mem_ack
    );
endinterface

// File: rtl/jt900h_blkxfer.sv
// Sequencer for LDI/LDIR/LDD/LDDR (byte and word): read/write pairs with
// pointer/count write-back once per iteration.
//
// state | meaning
// IDLE  | waiting for start; operands latched on start
// RD    | read request at XHL, held until ack
// WR    | write request at XDE with captured data, held until ack
// UPD   | register-file/flag write strobe; repeat, stop or interrupt decision
// FIN   | done pulse (with rewind when a repeat was interrupted)
module jt900h_blkxfer #(
    parameter int AW = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic        start,
    input  logic        rep,
    input  logic        dir,
    input  logic        wsize,
    input  logic [31:0] xhl_in,
    input  logic [31:0] xde_in,
    input  logic [15:0] bc_in,
    input  logic        irq,
    jt900h_blkxfer_if.master mem,
    output logic        reg_we,
    output logic [31:0] xhl_out,
    output logic [31:0] xde_out,
    output logic [15:0] bc_out,
    output logic        flag_v,
    output logic        flag_we,
    output logic        busy,
    output logic        done,
    output logic        rewind
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WR   = 3'd2,
        UPD  = 3'd3,
        FIN  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] xhl_q, xhl_d;
    logic [31:0] xde_q, xde_d;
    logic [15:0] bc_q, bc_d;
    logic        rep_q, rep_d;
    logic        dir_q, dir_d;
    logic        wsize_q, wsize_d;
    logic [15:0] data_q, data_d;
    logic        rewind_q, rewind_d;
    logic [31:0] xhl_out_q, xhl_out_d;
    logic [31:0] xde_out_q, xde_out_d;
    logic [15:0] bc_out_q, bc_out_d;
    logic        flag_v_q, flag_v_d;

    logic [31:0] step;
    logic [31:0] xhl_nx;
    logic [31:0] xde_nx;
    logic [15:0] bc_nx;
    logic        more;

    always_comb begin
        step   = wsize_q ? 32'd2 : 32'd1;
        xhl_nx = dir_q ? (xhl_q - step) : (xhl_q + step);
        xde_nx = dir_q ? (xde_q - step) : (xde_q + step);
        bc_nx  = bc_q - 16'd1;
        // In UPD the working count already holds the decremented value
        more   = rep_q && (bc_q != 16'd0);

        state_d   = state_q;
        xhl_d     = xhl_q;
        xde_d     = xde_q;
        bc_d      = bc_q;
        rep_d     = rep_q;
        dir_d     = dir_q;
        wsize_d   = wsize_q;
        data_d    = data_q;
        rewind_d  = rewind_q;
        xhl_out_d = xhl_out_q;
        xde_out_d = xde_out_q;
        bc_out_d  = bc_out_q;
        flag_v_d  = flag_v_q;

        if (cen) begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        xhl_d    = xhl_in;
                        xde_d    = xde_in;
                        bc_d     = bc_in;
                        rep_d    = rep;
                        dir_d    = dir;
                        wsize_d  = wsize;
                        rewind_d = 1'b0;
                        state_d  = RD;
                    end
                end
                RD: begin
                    if (mem.mem_ack) begin
                        data_d  = wsize_q ? mem.mem_din : {8'h00, mem.mem_din[7:0]};
                        state_d = WR;
                    end
                end
                WR: begin
                    if (mem.mem_ack) begin
                        xhl_d     = xhl_nx;
                        xde_d     = xde_nx;
                        bc_d      = bc_nx;
                        xhl_out_d = xhl_nx;
                        xde_out_d = xde_nx;
                        bc_out_d  = bc_nx;
                        flag_v_d  = (bc_nx != 16'd0);
                        state_d   = UPD;
                    end
                end
                UPD: begin
                    rewind_d = more && irq;
                    state_d  = (more && !irq) ? RD : FIN;
                end
                FIN: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            xhl_q     <= '0;
            xde_q     <= '0;
            bc_q      <= '0;
            rep_q     <= 1'b0;
            dir_q     <= 1'b0;
            wsize_q   <= 1'b0;
            data_q    <= '0;
            rewind_q  <= 1'b0;
            xhl_out_q <= '0;
            xde_out_q <= '0;
            bc_out_q  <= '0;
            flag_v_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            xhl_q     <= xhl_d;
            xde_q     <= xde_d;
            bc_q      <= bc_d;
            rep_q     <= rep_d;
            dir_q     <= dir_d;
            wsize_q   <= wsize_d;
            data_q    <= data_d;
            rewind_q  <= rewind_d;
            xhl_out_q <= xhl_out_d;
            xde_out_q <= xde_out_d;
            bc_out_q  <= bc_out_d;
            flag_v_q  <= flag_v_d;
        end
    end

    // Requests are level-held; only the one-cycle strobes are cen-qualified
    assign mem.mem_rd   = (state_q == RD);
    assign mem.mem_wr   = (state_q == WR);
    assign mem.mem_addr = (state_q == RD) ? xhl_q[AW-1:0] :
                          (state_q == WR) ? xde_q[AW-1:0] : '0;
    assign mem.mem_dout = (state_q == WR) ? data_q : 16'h0000;

    assign reg_we  = (state_q == UPD) && cen;
    assign flag_we = (state_q == UPD) && cen;
    assign done    = (state_q == FIN) && cen;
    assign rewind  = (state_q == FIN) && cen && rewind_q;
    assign busy    = (state_q != IDLE);

    assign xhl_out = xhl_out_q;
    assign xde_out = xde_out_q;
    assign bc_out  = bc_out_q;
    assign flag_v  = flag_v_q;

endmodule

// File: tb/tb_jt900h_blkxfer.sv
// Self-checking bench for jt900h_blkxfer: transfer-level model with queues,
// a bus responder with wait states/cen toggling, and literal pin checks.
module tb_jt900h_blkxfer;
    localparam int AW = 24;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cen = 1'b1;
    logic        start = 1'b0;
    logic        rep = 1'b0;
    logic        dir = 1'b0;
    logic        wsize = 1'b0;
    logic        irq = 1'b0;
    logic [31:0] xhl_in = '0;
    logic [31:0] xde_in = '0;
    logic [15:0] bc_in = '0;
    logic        reg_we, flag_v, flag_we, busy, done, rewind;
    logic [31:0] xhl_out, xde_out;
    logic [15:0] bc_out;

    jt900h_blkxfer_if #(.AW(AW)) bif ();

    jt900h_blkxfer #(.AW(AW)) dut (
        .clk     (clk),
        .rst     (rst),
        .cen     (cen),
        .start   (start),
        .rep     (rep),
        .dir     (dir),
        .wsize   (wsize),
        .xhl_in  (xhl_in),
        .xde_in  (xde_in),
        .bc_in   (bc_in),
        .irq     (irq),
        .mem     (bif),
        .reg_we  (reg_we),
        .xhl_out (xhl_out),
        .xde_out (xde_out),
        .bc_out  (bc_out),
        .flag_v  (flag_v),
        .flag_we (flag_we),
        .busy    (busy),
        .done    (done),
        .rewind  (rewind)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] xhl;
        logic [31:0] xde;
        logic [15:0] bc;
        logic        fv;
    } we_t;

    int n_cmp = 0;
    int n_err = 0;

    logic [AW-1:0] q_rd[$];
    logic [AW-1:0] q_wa[$];
    logic [15:0]   q_wd[$];
    we_t           q_we[$];
    logic          q_rw[$];
    logic [AW-1:0] seen_rd[$];

    int  cyc = 0, start_cyc = 0, done_cyc = 0, done_cnt = 0, we_cnt = 0;
    int  wait_cyc = 0, irq_iter = 0;
    bit  cen_mode = 1'b0;
    we_t ew;
    we_t last_we;
    logic last_rw;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: event seen at cycle %0d, none expected", name, cyc);
    endtask

    function automatic logic [15:0] mem_val(logic [AW-1:0] a);
        return {a[7:0] ^ 8'h5A, a[7:0] + 8'h33};
    endfunction

    // Transfer-level model: list of read/write pairs, write-backs and final rewind
    task automatic model(logic [31:0] s, logic [31:0] d, logic [15:0] c,
                         logic r, logic dr, logic ws, int irq_n);
        logic [31:0] st;
        logic [15:0] v;
        int n;
        bit go;
        st = ws ? 32'd2 : 32'd1;
        n  = 0;
        go = 1'b1;
        while (go) begin
            v = mem_val(s[AW-1:0]);
            q_rd.push_back(s[AW-1:0]);
            q_wa.push_back(d[AW-1:0]);
            q_wd.push_back(ws ? v : {8'h00, v[7:0]});
            s = dr ? s - st : s + st;
            d = dr ? d - st : d + st;
            c = c - 16'd1;
            n++;
            q_we.push_back('{s, d, c, (c != 16'd0)});
            if (!r || c == 16'd0) begin
                go = 1'b0;
                q_rw.push_back(1'b0);
            end else if (irq_n != 0 && n >= irq_n) begin
                go = 1'b0;
                q_rw.push_back(1'b1);
            end
        end
    endtask

    // Bus responder, cen and irq drivers (all updated on the falling edge)
    initial begin
        int wcnt;
        wcnt = 0;
        bif.mem_ack = 1'b0;
        bif.mem_din = 16'h0000;
        forever begin
            @(negedge clk);
            if (bif.mem_ack && cen) wcnt = 0;
            else if (bif.mem_rd || bif.mem_wr) wcnt++;
            else wcnt = 0;
            cen = cen_mode ? ~cen : 1'b1;
            irq = (irq_iter != 0) && (we_cnt >= irq_iter - 1);
            bif.mem_ack = !rst && (bif.mem_rd || bif.mem_wr) && (wcnt >= wait_cyc);
            bif.mem_din = bif.mem_rd ? mem_val(bif.mem_addr) : 16'hFFFF;
        end
    end

    // Compare process: every cycle, against the model queues
    initial begin
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            if (!rst) begin
                if (cen && start && !busy) start_cyc = cyc;
                if (bif.mem_rd && bif.mem_wr) unexpected("rd_and_wr");
                if (reg_we !== flag_we) unexpected("flag_we_pair");
                if (bif.mem_rd) begin
                    if (q_rd.size() == 0) unexpected("extra_rd");
                    else begin
                        check("rd_addr", bif.mem_addr, q_rd[0]);
                        if (cen && bif.mem_ack) begin
                            seen_rd.push_back(bif.mem_addr);
                            void'(q_rd.pop_front());
                        end
                    end
                end
                if (bif.mem_wr) begin
                    if (q_wa.size() == 0) unexpected("extra_wr");
                    else begin
                        check("wr_addr", bif.mem_addr, q_wa[0]);
                        check("wr_data", bif.mem_dout, q_wd[0]);
                        if (cen && bif.mem_ack) begin
                            void'(q_wa.pop_front());
                            void'(q_wd.pop_front());
                        end
                    end
                end
                if (reg_we) begin
                    if (q_we.size() == 0) unexpected("extra_reg_we");
                    else begin
                        ew = q_we.pop_front();
                        check("xhl_out", xhl_out, ew.xhl);
                        check("xde_out", xde_out, ew.xde);
                        check("bc_out", bc_out, ew.bc);
                        check("flag_v", flag_v, ew.fv);
                    end
                    last_we = '{xhl_out, xde_out, bc_out, flag_v};
                    we_cnt++;
                end
                if (done) begin
                    if (q_rw.size() == 0) unexpected("extra_done");
                    else check("rewind", rewind, q_rw.pop_front());
                    last_rw  = rewind;
                    done_cnt++;
                    done_cyc = cyc;
                end else if (rewind) begin
                    unexpected("rewind_without_done");
                end
            end
        end
    end

    task automatic clear_queues();
        q_rd.delete();
        q_wa.delete();
        q_wd.delete();
        q_we.delete();
        q_rw.delete();
    endtask

    task automatic launch(logic [31:0] s, logic [31:0] d, logic [15:0] c,
                          logic r, logic dr, logic ws);
        int k;
        seen_rd.delete();
        we_cnt = 0;
        @(negedge clk);
        xhl_in = s; xde_in = d; bc_in = c; rep = r; dir = dr; wsize = ws;
        start = 1'b1;
        k = 0;
        while (!busy && k < 50) begin
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        if (!busy) unexpected("start_timeout");
    endtask

    task automatic run_op(logic [31:0] s, logic [31:0] d, logic [15:0] c,
                          logic r, logic dr, logic ws, int irq_n, bit poke);
        int k, d0;
        model(s, d, c, r, dr, ws, irq_n);
        irq_iter = irq_n;
        d0 = done_cnt;
        launch(s, d, c, r, dr, ws);
        if (poke) begin
            xhl_in = 32'hDEAD0000; xde_in = 32'h0BAD0000; bc_in = 16'h0055;
            start = 1'b1;
            repeat (3) @(negedge clk);
            start = 1'b0;
        end
        k = 0;
        while (done_cnt == d0 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (done_cnt == d0) unexpected("done_timeout");
        irq_iter = 0;
        repeat (2) @(negedge clk);
        check("busy_after_done", busy, 1'b0);
        check("left_rd", q_rd.size(), 0);
        check("left_wr", q_wa.size(), 0);
        check("left_we", q_we.size(), 0);
        check("left_done", q_rw.size(), 0);
        clear_queues();
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_outs"},
              {bif.mem_rd, bif.mem_wr, reg_we, flag_we, busy, done, rewind, flag_v}, 8'h00);
        check({tag, "_addr"}, bif.mem_addr, 0);
        check({tag, "_dout"}, bif.mem_dout, 0);
        check({tag, "_xhl"}, xhl_out, 0);
        check({tag, "_xde"}, xde_out, 0);
        check({tag, "_bc"}, bc_out, 0);
    endtask

    initial begin
        int k;
        repeat (2) @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // LDI byte
        run_op(32'h1000, 32'h2000, 16'd3, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        check("t1_latency", done_cyc - start_cyc, 4);
        check("t1_xhl", last_we.xhl, 32'h1001);
        check("t1_xde", last_we.xde, 32'h2001);
        check("t1_bc", last_we.bc, 16'd2);
        check("t1_fv", last_we.fv, 1'b1);
        check("t1_reads", seen_rd.size(), 1);

        // LDIR word
        run_op(32'h100, 32'h200, 16'd4, 1'b1, 1'b0, 1'b1, 0, 1'b0);
        check("t2_reads", seen_rd.size(), 4);
        if (seen_rd.size() == 4) begin
            check("t2_rd0", seen_rd[0], 24'h000100);
            check("t2_rd3", seen_rd[3], 24'h000106);
        end
        check("t2_xhl", last_we.xhl, 32'h108);
        check("t2_bc", last_we.bc, 16'd0);
        check("t2_fv", last_we.fv, 1'b0);
        check("t2_rewind", last_rw, 1'b0);

        // LDDR byte with pointer wrap
        run_op(32'h1, 32'h10, 16'd3, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        check("t3_reads", seen_rd.size(), 3);
        if (seen_rd.size() == 3) begin
            check("t3_rd0", seen_rd[0], 24'h000001);
            check("t3_rd1", seen_rd[1], 24'h000000);
            check("t3_rd2", seen_rd[2], 24'hFFFFFF);
        end
        check("t3_xhl", last_we.xhl, 32'hFFFFFFFE);

        // LDIR interrupted during the third iteration
        run_op(32'h3000, 32'h4000, 16'd10, 1'b1, 1'b0, 1'b0, 3, 1'b0);
        check("t4_pairs", seen_rd.size(), 3);
        check("t4_bc", last_we.bc, 16'd7);
        check("t4_rewind", last_rw, 1'b1);

        // Wait states and cen toggling
        wait_cyc = 5;
        cen_mode = 1'b1;
        run_op(32'h500, 32'h600, 16'd2, 1'b1, 1'b0, 1'b1, 0, 1'b0);
        cen_mode = 1'b0;
        wait_cyc = 0;
        check("t5_we_count", we_cnt, 2);
        check("t5_xhl", last_we.xhl, 32'h504);

        // BC=0 single form
        run_op(32'h10, 32'h20, 16'd0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        check("t6_bc", last_we.bc, 16'hFFFF);
        check("t6_fv", last_we.fv, 1'b1);

        // start while busy is ignored
        run_op(32'h700, 32'h800, 16'd2, 1'b1, 1'b0, 1'b0, 0, 1'b1);
        check("t6_poke_reads", seen_rd.size(), 2);
        check("t6_poke_xhl", last_we.xhl, 32'h702);

        // reset in the middle of a write
        wait_cyc = 20;
        model(32'hA00, 32'hB00, 16'd5, 1'b1, 1'b0, 1'b0, 0);
        launch(32'hA00, 32'hB00, 16'd5, 1'b1, 1'b0, 1'b0);
        k = 0;
        while (!bif.mem_wr && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!bif.mem_wr) unexpected("wr_timeout");
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        clear_queues();
        wait_cyc = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        run_op(32'h900, 32'hA00, 16'd1, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        check("t6_after_rst_xhl", last_we.xhl, 32'h902);
        check("t6_after_rst_bc", last_we.bc, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/jt900h_blkxfer.md
Name: jt900h_blkxfer

Overview:
- Sequencer for the TLCS-900H block-transfer instructions LDI, LDIR, LDD and LDDR, in byte and word forms.
- Sits between the instruction decoder, the register file and the memory bus.
- Takes snapshots of XHL (source), XDE (destination) and BC (count), then runs read/write memory cycles.
- Writes the updated pointers and count back through a single write-back strobe per iteration.

Parameters:
AW, 24, width of the mem_addr bus (low AW bits of the 32-bit pointers)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cen  in  1  clock enable; all state advances only when cen=1
- start  in  1  begin a transfer; sampled in IDLE only
- rep  in  1  1: repeat until BC reaches 0 (LDIR/LDDR); 0: single iteration
- dir  in  1  0: increment pointers; 1: decrement pointers
- wsize  in  1  0: byte units; 1: 16-bit word units
- xhl_in  in  32  source pointer, sampled at start
- xde_in  in  32  destination pointer, sampled at start
- bc_in  in  16  count, sampled at start
- irq  in  1  interrupt pending; checked between repeat iterations
- mem_addr  out  AW  bus address
- mem_rd  out  1  read request, held until ack
- mem_wr  out  1  write request, held until ack
- mem_dout  out  16  write data
- mem_din  in  16  read data, valid with mem_ack
- mem_ack  in  1  completes the current request
- reg_we  out  1  one-cycle strobe: write xhl_out, xde_out, bc_out to the register file
- xhl_out  out  32  updated source pointer
- xde_out  out  32  updated destination pointer
- bc_out  out  16  updated count
- flag_v  out  1  P/V flag = (bc_out != 0); valid with flag_we
- flag_we  out  1  flag write strobe, coincident with reg_we
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse on completion
- rewind  out  1  with done: PC must be rewound to re-execute the instruction (interrupted repeat)

Behaviour:
- Reset: state=IDLE. All outputs are 0: mem_rd, mem_wr, reg_we, flag_we, busy, done, rewind, mem_addr, mem_dout, xhl_out, xde_out, bc_out, flag_v.
- cen=0 freezes the state and all registers. Strobes are qualified with cen: they last exactly one cen-active cycle.
- States: IDLE, RD, WR, UPD, FIN.
- IDLE:
  - start=1 latches xhl_in/xde_in/bc_in/rep/dir/wsize and goes to RD next cycle.
  - start in any other state is ignored.
- RD:
  - mem_rd=1, mem_addr=xhl[AW-1:0].
  - On mem_ack, capture mem_din (byte mode keeps bits [7:0]; the upper byte of mem_dout is 0) and go to WR.
  - No ack: hold the state and the outputs stable.
- WR:
  - mem_wr=1, mem_addr=xde[AW-1:0], mem_dout=captured data.
  - On mem_ack, go to UPD.
- UPD (one cycle):
  - step = 1 for byte, 2 for word.
  - xhl ± step and xde ± step, with 32-bit modular wrap (0x00000000 - 1 = 0xFFFFFFFF).
  - bc = bc - 1, with 16-bit wrap.
  - reg_we=1 and flag_we=1; outputs carry the new values; flag_v = (new bc != 0).
  - Next state:
    - rep=1, new bc != 0, irq=0: go to RD.
    - rep=1, new bc != 0, irq=1: go to FIN with rewind=1.
    - Otherwise: go to FIN with rewind=0.
- FIN (one cycle): done=1, rewind as decided in UPD; go to IDLE.
- BC=0 at start: the first iteration wraps BC to 0xFFFF. A repeat form therefore transfers 65536 units. A single form transfers 1 unit with flag_v=1.
- Latency with a zero-wait bus (ack in the same cycle as the request): 3 cycles per iteration, plus 1 cycle for FIN.
- irq is only examined in UPD. An interrupt never splits a read/write pair.
- Reset mid-operation aborts immediately to IDLE. No reg_we is issued, and the register file keeps its last written values.
- xhl_out/xde_out/bc_out hold their last values between strobes.

Test Plan:
1. LDI byte: xhl=0x1000, xde=0x2000, bc=3, rep=0, dir=0, zero-wait bus -> 1 read @0x1000, 1 write @0x2000; reg_we with xhl_out=0x1001, xde_out=0x2001, bc_out=2, flag_v=1; done 4 cycles after start.
2. LDIR word: xhl=0x100, xde=0x200, bc=4 -> 4 read/write pairs (reads at 0x100, 0x102, 0x104, 0x106); final bc_out=0, flag_v=0, xhl_out=0x108; done with rewind=0.
3. LDDR byte with pointer wrap: xhl=0x00000001, xde=0x10, bc=3 -> read addresses 0x000001, 0x000000, 0xFFFFFF (AW=24); final xhl_out=0xFFFFFFFE.
4. Interrupt: LDIR with bc=10, irq asserted during the 3rd iteration -> exactly 3 pairs; bc_out=7; done with rewind=1.
5. Wait states plus cen: ack delayed 5 cycles and cen toggling -> mem_rd/mem_addr stable until ack; no duplicate reg_we.
6. Edge cases: bc=0 with rep=0 -> bc_out=0xFFFF, flag_v=1. start asserted while busy -> ignored. rst mid-WR -> all outputs 0, next start behaves normally.
